// File: rtl/vga_scan_driver_if.sv
// ============================================================================
// Module  : vga_scan_driver_if
// Purpose : Raster, colour and snapshot signals between the scan driver and
//           the screen colouring logic / VGA pins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_scan_driver_if;
  logic [47:0] numbers_concat;
  logic [2:0]  pix_r;
  logic [2:0]  pix_g;
  logic [1:0]  pix_b;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic [47:0] numbers_latched;
  logic        pix_stb;
  logic        frame_start;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;

  modport master (
    input  numbers_concat, pix_r, pix_g, pix_b,
    output sx, sy, numbers_latched, pix_stb, frame_start,
           vga_hsync, vga_vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output numbers_concat, pix_r, pix_g, pix_b,
    input  sx, sy, numbers_latched, pix_stb, frame_start,
           vga_hsync, vga_vsync, vga_r, vga_g, vga_b
  );
endinterface

`default_nettype wire

// File: rtl/vga_scan_driver.sv
// ============================================================================
// Module  : vga_scan_driver
// Purpose : VGA pixel strobe, scan counters, sync generation, registered
//           colour output and frame-boundary snapshot of the display numbers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scan_driver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_driver_if.master bus
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [c_DIV_W-1:0] r_div;
  logic [9:0]         r_sx;
  logic [9:0]         r_sy;
  logic [47:0]        r_numbers;
  logic [2:0]         r_vga_r;
  logic [2:0]         r_vga_g;
  logic [1:0]         r_vga_b;
  logic               r_hsync;
  logic               r_vsync;

  logic w_pix_stb;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_start;
  logic w_de;
  logic w_hsync_raw;
  logic w_vsync_raw;

  assign w_pix_stb     = (r_div == c_DIV_LAST);
  assign w_h_last      = (r_sx == c_H_LAST);
  assign w_v_last      = (r_sy == c_V_LAST);
  assign w_frame_start = w_pix_stb && w_h_last && w_v_last;
  assign w_de          = (r_sx < c_H_VIS) && (r_sy < c_V_VIS);
  assign w_hsync_raw   = !((r_sx >= c_HS_START) && (r_sx < c_HS_END));
  assign w_vsync_raw   = !((r_sy >= c_VS_START) && (r_sy < c_VS_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_stb) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Wrap on exact equality so the counters can never leave the raster.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (w_pix_stb) begin
      if (w_h_last) begin
        r_sx <= '0;
        r_sy <= w_v_last ? 10'd0 : r_sy + 10'd1;
      end else begin
        r_sx <= r_sx + 10'd1;
      end
    end
  end

  // Colour and sync share this stage so they stay pixel-aligned at the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pix_stb) begin
      r_vga_r <= w_de ? bus.pix_r : 3'd0;
      r_vga_g <= w_de ? bus.pix_g : 3'd0;
      r_vga_b <= w_de ? bus.pix_b : 2'd0;
      r_hsync <= w_hsync_raw;
      r_vsync <= w_vsync_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_numbers <= '0;
    end else if (w_frame_start) begin
      r_numbers <= bus.numbers_concat;
    end
  end

  assign bus.sx              = r_sx;
  assign bus.sy              = r_sy;
  assign bus.numbers_latched = r_numbers;
  assign bus.pix_stb         = w_pix_stb;
  assign bus.frame_start     = w_frame_start;
  assign bus.vga_hsync       = r_hsync;
  assign bus.vga_vsync       = r_vsync;
  assign bus.vga_r           = r_vga_r;
  assign bus.vga_g           = r_vga_g;
  assign bus.vga_b           = r_vga_b;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
// ============================================================================
// Module  : tb_vga_scan_driver
// Purpose : Directed self-checking bench; a full-size instance for reset and
//           line timing, a reduced-raster instance for frame-level behaviour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_driver;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  localparam logic [47:0] c_OLD = 48'h0123456789AB;
  localparam logic [47:0] c_NEW = 48'hFEDCBA987654;

  // Reduced raster: H 16+4+6+4 = 30, V 12+2+2+3 = 19, 2280 clocks per frame.
  localparam int c_BH = 30;
  localparam int c_BV = 19;
  localparam int c_BFRAME = c_BH * c_BV * 4;

  vga_scan_driver_if bus_a ();
  vga_scan_driver_if bus_b ();

  vga_scan_driver dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  vga_scan_driver #(
    .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
    .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .CLK_DIV   (4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench on the negedge where cycle 0 after release begins.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus_a.sx !== 10'd0 || bus_a.sy !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_sxsy: got sx=%0d sy=%0d expected 0 0", bus_a.sx, bus_a.sy);
    end
    tests_run++;
    if (bus_a.numbers_latched !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_latched: got %h expected 0", bus_a.numbers_latched);
    end
    tests_run++;
    if ({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b} !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_rgb: got %0d/%0d/%0d expected 0/0/0", bus_a.vga_r, bus_a.vga_g, bus_a.vga_b);
    end
    tests_run++;
    if ({bus_a.vga_hsync, bus_a.vga_vsync, bus_a.pix_stb, bus_a.frame_start} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got hs,vs,stb,fs=%b%b%b%b expected 1100",
               bus_a.vga_hsync, bus_a.vga_vsync, bus_a.pix_stb, bus_a.frame_start);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (bus_a.pix_stb !== ((k % 4) == 3)) begin
        tests_failed++;
        $display("FAIL reset_stb_phase: cycle %0d got %b expected %b", k, bus_a.pix_stb, (k % 4) == 3);
      end
      if (k == 4) begin
        tests_run++;
        if (bus_a.sx !== 10'd1 || bus_a.sy !== 10'd0) begin
          tests_failed++;
          $display("FAIL reset_first_step: got sx=%0d sy=%0d expected 1 0", bus_a.sx, bus_a.sy);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_line();
    int stb_idx;
    int hs_low;
    int first_low;
    stb_idx   = 0;
    hs_low    = 0;
    first_low = -1;
    apply_reset();
    for (int cyc = 0; cyc < 3208; cyc++) begin
      if (bus_a.pix_stb === 1'b1) begin
        if (stb_idx == 799) begin
          tests_run++;
          if (bus_a.sx !== 10'd799 || bus_a.sy !== 10'd0) begin
            tests_failed++;
            $display("FAIL line_end: got sx=%0d sy=%0d expected 799 0", bus_a.sx, bus_a.sy);
          end
        end
        if (stb_idx == 800) begin
          tests_run++;
          if (bus_a.sx !== 10'd0 || bus_a.sy !== 10'd1) begin
            tests_failed++;
            $display("FAIL line_wrap: got sx=%0d sy=%0d expected 0 1", bus_a.sx, bus_a.sy);
          end
        end
        if (stb_idx >= 1 && stb_idx <= 800 && bus_a.vga_hsync === 1'b0) begin
          hs_low++;
          if (first_low < 0) first_low = int'(bus_a.sx);
        end
        stb_idx++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (stb_idx != 802) begin
      tests_failed++;
      $display("FAIL line_stb_count: got %0d expected 802", stb_idx);
    end
    tests_run++;
    if (hs_low != 96) begin
      tests_failed++;
      $display("FAIL line_hsync_width: got %0d expected 96", hs_low);
    end
    tests_run++;
    if (first_low != 657) begin
      tests_failed++;
      $display("FAIL line_hsync_start: got sx=%0d expected 657", first_low);
    end
  endtask

  task automatic test_frame();
    int stb_idx, fs_count, fs1, fs2, vs_low, vs_sx, vs_sy, max_sx, max_sy;
    stb_idx = 0; fs_count = 0; fs1 = -1; fs2 = -1;
    vs_low = 0; vs_sx = -1; vs_sy = -1; max_sx = 0; max_sy = 0;
    apply_reset();
    for (int cyc = 0; cyc < 4600; cyc++) begin
      if (int'(bus_b.sx) > max_sx) max_sx = int'(bus_b.sx);
      if (int'(bus_b.sy) > max_sy) max_sy = int'(bus_b.sy);
      if (bus_b.frame_start === 1'b1) begin
        fs_count++;
        if (fs1 < 0) begin
          fs1 = cyc;
          tests_run++;
          if (bus_b.sx !== 10'd29 || bus_b.sy !== 10'd18) begin
            tests_failed++;
            $display("FAIL frame_start_pos: got sx=%0d sy=%0d expected 29 18", bus_b.sx, bus_b.sy);
          end
        end else if (fs2 < 0) begin
          fs2 = cyc;
        end
      end
      if (bus_b.pix_stb === 1'b1) begin
        if (stb_idx >= 1 && stb_idx <= 570 && bus_b.vga_vsync === 1'b0) begin
          vs_low++;
          if (vs_sx < 0) begin
            vs_sx = int'(bus_b.sx);
            vs_sy = int'(bus_b.sy);
          end
        end
        stb_idx++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (fs_count != 2 || fs1 != c_BFRAME - 1) begin
      tests_failed++;
      $display("FAIL frame_first: got count=%0d at=%0d expected 2 at %0d", fs_count, fs1, c_BFRAME - 1);
    end
    tests_run++;
    if (fs2 - fs1 != c_BFRAME) begin
      tests_failed++;
      $display("FAIL frame_length: got %0d expected %0d", fs2 - fs1, c_BFRAME);
    end
    tests_run++;
    if (vs_low != 2 * c_BH) begin
      tests_failed++;
      $display("FAIL frame_vsync_width: got %0d expected %0d", vs_low, 2 * c_BH);
    end
    tests_run++;
    if (vs_sx != 1 || vs_sy != 14) begin
      tests_failed++;
      $display("FAIL frame_vsync_start: got sx=%0d sy=%0d expected 1 14", vs_sx, vs_sy);
    end
    tests_run++;
    if (max_sx != c_BH - 1 || max_sy != c_BV - 1) begin
      tests_failed++;
      $display("FAIL frame_bounds: got max sx=%0d sy=%0d expected %0d %0d", max_sx, max_sy, c_BH - 1, c_BV - 1);
    end
  endtask

  // Colour is presented only on strobe cycles so a design that samples on
  // every clock registers zero instead of 7/7/3.
  task automatic test_colour();
    int stb_idx, p, px, py;
    logic [7:0] exp_rgb;
    stb_idx = 0;
    bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
    apply_reset();
    for (int cyc = 0; cyc < c_BFRAME + 4; cyc++) begin
      if (bus_b.pix_stb === 1'b1) begin
        tests_run++;
        if (int'(bus_b.sx) != stb_idx % c_BH || int'(bus_b.sy) != (stb_idx / c_BH) % c_BV) begin
          tests_failed++;
          $display("FAIL colour_scan_pos: strobe %0d got sx=%0d sy=%0d expected %0d %0d", stb_idx,
                   bus_b.sx, bus_b.sy, stb_idx % c_BH, (stb_idx / c_BH) % c_BV);
        end
        if (stb_idx >= 1) begin
          p  = stb_idx - 1;
          px = p % c_BH;
          py = (p / c_BH) % c_BV;
          exp_rgb = (px < 16 && py < 12) ? 8'b111_111_11 : 8'd0;
          tests_run++;
          if ({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b} !== exp_rgb) begin
            tests_failed++;
            $display("FAIL colour_pixel: pixel (%0d,%0d) got %0d/%0d/%0d expected rgb=%b", px, py,
                     bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, exp_rgb);
          end
        end
        stb_idx++;
      end
      if (bus_b.pix_stb === 1'b1) begin
        bus_b.pix_r = 3'd7; bus_b.pix_g = 3'd7; bus_b.pix_b = 2'd3;
      end else begin
        bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
      end
      @(negedge clk);
      if (bus_b.pix_stb !== 1'b1) begin
        bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
      end else begin
        bus_b.pix_r = 3'd7; bus_b.pix_g = 3'd7; bus_b.pix_b = 2'd3;
      end
    end
    bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
  endtask

  task automatic test_snapshot();
    logic [47:0] exp_num;
    logic changed;
    changed = 1'b0;
    bus_b.numbers_concat = c_OLD;
    apply_reset();
    for (int cyc = 0; cyc < 2 * c_BFRAME + 8; cyc++) begin
      if (cyc < c_BFRAME)          exp_num = 48'd0;
      else if (cyc < 2 * c_BFRAME) exp_num = c_OLD;
      else                         exp_num = c_NEW;
      tests_run++;
      if (bus_b.numbers_latched !== exp_num) begin
        tests_failed++;
        $display("FAIL snapshot_value: cycle %0d got %h expected %h", cyc, bus_b.numbers_latched, exp_num);
      end
      if (!changed && cyc > c_BFRAME && bus_b.sy == 10'd8) begin
        bus_b.numbers_concat = c_NEW;
        changed = 1'b1;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!changed) begin
      tests_failed++;
      $display("FAIL snapshot_midframe_change: got no sy=8 point expected one");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    found = 1'b0;
    bus_b.numbers_concat = c_NEW;
    bus_b.pix_r = 3'd7; bus_b.pix_g = 3'd7; bus_b.pix_b = 2'd3;
    apply_reset();
    for (int cyc = 0; cyc < 2 * c_BFRAME && !found; cyc++) begin
      if (cyc > c_BFRAME && bus_b.sx == 10'd12 && bus_b.sy == 10'd10 && bus_b.pix_stb === 1'b0)
        found = 1'b1;
      else
        @(negedge clk);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midreset_reach: got no (12,10) within bound expected it");
    end else begin
      tests_run++;
      if (bus_b.numbers_latched !== c_NEW || bus_b.vga_r !== 3'd7) begin
        tests_failed++;
        $display("FAIL midreset_pre: got latched=%h r=%0d expected %h 7", bus_b.numbers_latched, bus_b.vga_r, c_NEW);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (bus_b.sx !== 10'd0 || bus_b.sy !== 10'd0 || bus_b.numbers_latched !== 48'd0) begin
        tests_failed++;
        $display("FAIL midreset_clear_state: got sx=%0d sy=%0d latched=%h expected 0 0 0",
                 bus_b.sx, bus_b.sy, bus_b.numbers_latched);
      end
      tests_run++;
      if ({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b} !== 8'd0 ||
          {bus_b.vga_hsync, bus_b.vga_vsync, bus_b.pix_stb, bus_b.frame_start} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL midreset_clear_out: got rgb=%0d/%0d/%0d hs,vs,stb,fs=%b%b%b%b expected 0/0/0 1100",
                 bus_b.vga_r, bus_b.vga_g, bus_b.vga_b,
                 bus_b.vga_hsync, bus_b.vga_vsync, bus_b.pix_stb, bus_b.frame_start);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (bus_b.pix_stb !== ((k % 4) == 3)) begin
          tests_failed++;
          $display("FAIL midreset_stb_phase: cycle %0d got %b expected %b", k, bus_b.pix_stb, (k % 4) == 3);
        end
        if (k == 4) begin
          tests_run++;
          if (bus_b.sx !== 10'd1 || bus_b.sy !== 10'd0 || bus_b.numbers_latched !== 48'd0) begin
            tests_failed++;
            $display("FAIL midreset_restart: got sx=%0d sy=%0d latched=%h expected 1 0 0",
                     bus_b.sx, bus_b.sy, bus_b.numbers_latched);
          end
        end
        @(negedge clk);
      end
    end
    bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    bus_a.numbers_concat = 48'd0;
    bus_a.pix_r = 3'd0; bus_a.pix_g = 3'd0; bus_a.pix_b = 2'd0;
    bus_b.numbers_concat = 48'd0;
    bus_b.pix_r = 3'd0; bus_b.pix_g = 3'd0; bus_b.pix_b = 2'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_colour();
    test_snapshot();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
